// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: turns single cmd/rsp handshakes into APB4 transfers.
// Ports: PCLK/PRESETn; cmd_* request in; rsp_* response out; APB4 P* bus.
//   cmd_valid/ready  accept one command while idle
//   rsp_valid/ready  hold rdata/err/timeout until consumed
//   PSELx..PPROT     APB4 request, PRDATA/PREADY/PSLVERR completion
module apb4_master_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                PSELx,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic [2:0]          PPROT,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [2:0]          pprot_q, pprot_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                tout_q, tout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                limit_hit;

    // cnt_q holds the PREADY-low ACCESS cycles already seen, so the
    // current low cycle is the TIMEOUT-th one when cnt_q == TIMEOUT-1.
    generate
        if (TIMEOUT > 0) begin : g_tout
            assign limit_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_tout
            assign limit_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        pprot_d  = pprot_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tout_d   = tout_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    // reads never carry byte strobes on APB4
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    pprot_d  = cmd_prot;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // completion wins over a timeout landing in the same cycle
                if (PREADY) begin
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    tout_d  = 1'b0;
                    state_d = RESP;
                end else if (limit_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            pprot_q  <= pprot_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tout_q   <= tout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign PSELx       = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE     = (state_q == ACCESS);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tout_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge: random and directed APB4 transfers with a
// transaction-level expectation model; TIMEOUT is set to 4.
module tb_apb4_master_bridge;

    localparam int TO = 4;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_cmp = 0;
    int n_err = 0;

    apb4_master_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .cmd_prot   (cmd_prot),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PPROT      (PPROT),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic junk_cmd();
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    task automatic junk_bus(input logic rdy);
        PREADY  = rdy;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
    endtask

    // Starts and ends at a negedge with the bridge idle. waits = number of
    // PREADY-low ACCESS cycles the slave would insert before completing.
    task automatic xfer(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p, input int waits,
                        input bit serr, input logic [31:0] rd,
                        input int hold, input bit busy);
        bit          timed;
        int          nacc;
        logic [3:0]  e_strb;
        logic [31:0] e_rd;
        logic        e_err;
        logic [41:0] e_bus;
        timed  = (waits >= TO);
        nacc   = timed ? TO : waits + 1;
        e_strb = wr ? s : 4'h0;
        e_rd   = (wr || timed) ? 32'h0 : rd;
        e_err  = timed ? 1'b1 : serr;
        chk("idle_ready", cmd_ready, 1);
        chk("idle_sel", {PSELx, PENABLE, rsp_valid}, 0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        junk_cmd();
        e_bus = {1'b1, 1'b0, wr, p, e_strb, a};
        chk("setup_bus", {PSELx, PENABLE, PWRITE, PPROT, PSTRB, PADDR}, e_bus);
        chk("setup_wdata", PWDATA, d);
        chk("setup_hs", {cmd_ready, rsp_valid}, 0);
        junk_bus(1'b1);
        for (int k = 1; k <= nacc; k++) begin
            @(negedge PCLK);
            e_bus = {1'b1, 1'b1, wr, p, e_strb, a};
            chk("acc_bus", {PSELx, PENABLE, PWRITE, PPROT, PSTRB, PADDR},
                e_bus);
            chk("acc_wdata", PWDATA, d);
            chk("acc_hs", {cmd_ready, rsp_valid}, 0);
            if (k == nacc && !timed) begin
                PREADY  = 1'b1;
                PSLVERR = serr;
                PRDATA  = rd;
            end else begin
                junk_bus(1'b0);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge PCLK);
            junk_bus(1'($urandom));
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, e_rd);
            chk("rsp_flags", {rsp_err, rsp_timeout}, {e_err, timed});
            chk("rsp_bus", {PSELx, PENABLE, cmd_ready}, 0);
            cmd_valid = busy;
            if (busy) junk_cmd();
            rsp_ready = (h == hold);
        end
        @(negedge PCLK);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("post_hs", {rsp_valid, PSELx, cmd_ready}, 3'b001);
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        junk_cmd();
        junk_bus(1'b1);
        repeat (3) @(negedge PCLK);
        chk("rst_ctl", {PSELx, PENABLE, PWRITE, rsp_valid, rsp_err,
                        rsp_timeout}, 0);
        chk("rst_addr", PADDR, 0);
        chk("rst_wdata", PWDATA, 0);
        chk("rst_sp", {PSTRB, PPROT}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        cmd_valid = 1'b0;
        PRESETn   = 1'b1;
        @(negedge PCLK);
        chk("rel_ready", cmd_ready, 1);

        xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0, 0, 0, 32'h0, 0, 0);
        xfer(0, 32'h20, 32'h0, 4'hF, 3'h2, 3, 0, 32'h12345678, 0, 0);
        xfer(1, 32'h34, 32'hCAFEF00D, 4'h3, 3'h1, 1, 1, 32'h0, 0, 0);
        xfer(0, 32'h40, 32'h0, 4'hF, 3'h5, 9, 0, 32'hA5A5A5A5, 1, 0);
        xfer(1, 32'h44, 32'h11223344, 4'hC, 3'h7, 0, 0, 32'h0, 5, 1);
        xfer(0, 32'h48, 32'h0, 4'h0, 3'h0, 0, 1, 32'h87654321, 0, 0);

        cmd_valid = 1'b1;
        junk_cmd();
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        @(negedge PCLK);
        chk("pre_rst_acc", {PSELx, PENABLE}, 2'b11);
        PRESETn   = 1'b0;
        cmd_valid = 1'b1;
        @(negedge PCLK);
        chk("mid_rst_bus", {PSELx, PENABLE, rsp_valid}, 0);
        chk("mid_rst_addr", PADDR, 0);
        PREADY = 1'b1;
        @(negedge PCLK);
        chk("mid_rst_hold", {PSELx, PENABLE, rsp_valid}, 0);
        cmd_valid = 1'b0;
        PRESETn   = 1'b1;
        @(negedge PCLK);
        chk("mid_rel", {cmd_ready, rsp_valid, PSELx}, 3'b100);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom),
                 3'($urandom), int'($urandom_range(0, 6)),
                 1'($urandom), $urandom, int'($urandom_range(0, 3)),
                 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
